regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter.sv | 136 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the single register_file write port between
// three writeback sources (0 = MEM load, 1 = ALU, 2 = MUL/DIV).
// Grants at most one request per cycle and registers the winner onto
// reg_write/write_reg/write_data one cycle later.
// Build option: define WB_RR_EN for a round-robin base policy; without it the
// base policy is fixed priority 0 > 1 > 2. Starvation promotion applies in both.
//
// Handshake: a transfer happens on req_valid[i] && req_ready[i]. A source keeps
// valid/reg/data stable until it sees ready. req_ready is combinational,
// one-hot for the winner, and all zero during rst, hold or when nothing is valid.
module regfile_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hold,
    input  logic [2:0]          req_valid,
    output logic [2:0]          req_ready,
    input  logic [3*ADDR_W-1:0] req_reg,
    input  logic [3*DATA_W-1:0] req_data,
    output logic                reg_write,
    output logic [ADDR_W-1:0]   write_reg,
    output logic [DATA_W-1:0]   write_data,
    output logic                grant_vld,
    output logic [1:0]          grant_id
);

    localparam logic [3:0] STARVE_TH = 4'(STARVE_MAX);

    logic [3:0]        wait_cnt [3];
    logic [2:0]        starved;
    logic              grant_any;
    logic [1:0]        grant_idx;
    logic [2:0]        grant;
    logic [ADDR_W-1:0] sel_reg;
    logic [DATA_W-1:0] sel_data;

`ifdef WB_RR_EN
    logic [1:0] rr_ptr;
`endif

    // A valid source that has lost STARVE_MAX or more cycles in a row is starved.
    always_comb begin
        starved = 3'b000;
        for (int i = 0; i < 3; i++) begin
            starved[i] = req_valid[i] && (wait_cnt[i] >= STARVE_TH);
        end
    end

    // Pick the winner: lowest starved source first, otherwise the base policy.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = 2'd0;
        if (!rst && !hold) begin
            if (|starved) begin
                grant_any = 1'b1;
                if (starved[0])      grant_idx = 2'd0;
                else if (starved[1]) grant_idx = 2'd1;
                else                 grant_idx = 2'd2;
            end else if (|req_valid) begin
                grant_any = 1'b1;
`ifdef WB_RR_EN
                // Walk the search order backwards so the last hit is the first in order.
                for (int k = 2; k >= 0; k--) begin
                    int cand;
                    cand = int'(rr_ptr) + k;
                    if (cand >= 3) cand = cand - 3;
                    if (req_valid[cand]) grant_idx = 2'(cand);
                end
`else
                if (req_valid[0])      grant_idx = 2'd0;
                else if (req_valid[1]) grant_idx = 2'd1;
                else                   grant_idx = 2'd2;
`endif
            end
        end
        grant = grant_any ? (3'b001 << grant_idx) : 3'b000;
    end

    assign req_ready = grant;

    // Route the winning source's address and data toward the output stage.
    always_comb begin
        case (grant_idx)
            2'd0:    begin sel_reg = req_reg[0 +: ADDR_W];        sel_data = req_data[0 +: DATA_W];        end
            2'd1:    begin sel_reg = req_reg[ADDR_W +: ADDR_W];   sel_data = req_data[DATA_W +: DATA_W];   end
            default: begin sel_reg = req_reg[2*ADDR_W +: ADDR_W]; sel_data = req_data[2*DATA_W +: DATA_W]; end
        endcase
    end

    // Per-source wait counters: count lost cycles, clear on grant or idle, freeze on hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) wait_cnt[i] <= 4'd0;
        end else if (!hold) begin
            for (int i = 0; i < 3; i++) begin
                if (!req_valid[i] || grant[i]) wait_cnt[i] <= 4'd0;
                else if (wait_cnt[i] != 4'hF) wait_cnt[i] <= wait_cnt[i] + 4'd1;
            end
        end
    end

`ifdef WB_RR_EN
    // Round-robin pointer moves just past whichever source was granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 2'd0;
        end else if (grant_any) begin
            rr_ptr <= (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
        end
    end
`endif

    // Output stage: register the granted write; writes to $zero are consumed but not enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write  <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
            grant_vld  <= 1'b0;
            grant_id   <= 2'd0;
        end else if (grant_any) begin
            reg_write  <= (sel_reg != '0);
            write_reg  <= sel_reg;
            write_data <= sel_data;
            grant_vld  <= 1'b1;
            grant_id   <= grant_idx;
        end else begin
            reg_write  <= 1'b0;
            grant_vld  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed arbitration sequences plus random
// single-source traffic, checked through an expected-write queue and a small
// register-file image.
module tb_regfile_wb_arbiter;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int STARVE_MAX = 4;
    localparam int W          = 2 + ADDR_W + DATA_W;

`ifdef WB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic                clk = 1'b0;
    logic                rst;
    logic                hold;
    logic [2:0]          req_valid;
    logic [2:0]          req_ready;
    logic [3*ADDR_W-1:0] req_reg;
    logic [3*DATA_W-1:0] req_data;
    logic                reg_write;
    logic [ADDR_W-1:0]   write_reg;
    logic [DATA_W-1:0]   write_data;
    logic                grant_vld;
    logic [1:0]          grant_id;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst), .hold(hold),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_reg(req_reg), .req_data(req_data),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
        .grant_vld(grant_vld), .grant_id(grant_id)
    );

    // ---------------- bench state ----------------
    logic [ADDR_W-1:0] src_reg  [3];
    logic [DATA_W-1:0] src_data [3];
    logic [W-1:0]      exp_q[$];
    logic [DATA_W-1:0] rf     [32];
    logic [DATA_W-1:0] exp_rf [32];
    logic [ADDR_W-1:0] last_reg;
    logic [DATA_W-1:0] last_data;
    logic [1:0]        last_id;
    int                checks = 0;
    int                errors = 0;

    // Register file image written from the DUT's write port.
    always @(posedge clk) begin
        if (reg_write) rf[write_reg] <= write_data;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7);
        pk = {16'hFFFF, 2'(a7), 2'(a6), 2'(a5), 2'(a4), 2'(a3), 2'(a2), 2'(a1), 2'(a0)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_srcs();
        for (int i = 0; i < 3; i++) begin
            req_reg[i*ADDR_W +: ADDR_W]  = src_reg[i];
            req_data[i*DATA_W +: DATA_W] = src_data[i];
        end
    endtask

    // One clock: drive, check ready, push the expected write, then check the output stage.
    task automatic cycle(input logic [2:0] v, input logic h, input logic r,
                         input logic g, input logic [1:0] id);
        logic [W-1:0]      e;
        logic [2:0]        exp_ready;
        logic [ADDR_W-1:0] e_reg;
        req_valid = v;
        hold      = h;
        rst       = r;
        drive_srcs();
        #1;
        exp_ready = g ? (3'b001 << id) : 3'b000;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        if (g) begin
            exp_q.push_back({id, src_reg[id], src_data[id]});
            if (src_reg[id] != '0) exp_rf[src_reg[id]] = src_data[id];
        end
        @(posedge clk);
        #1;
        if (r) begin
            last_reg  = '0;
            last_data = '0;
            last_id   = 2'd0;
        end
        if (g) begin
            e     = exp_q.pop_front();
            e_reg = e[DATA_W +: ADDR_W];
            check("grant_vld",  64'(grant_vld),  64'd1);
            check("grant_id",   64'(grant_id),   64'(e[W-1 -: 2]));
            check("write_reg",  64'(write_reg),  64'(e_reg));
            check("write_data", 64'(write_data), 64'(e[DATA_W-1:0]));
            check("reg_write",  64'(reg_write),  64'(e_reg != '0));
            last_reg  = e_reg;
            last_data = e[DATA_W-1:0];
            last_id   = e[W-1 -: 2];
        end else begin
            check("idle_grant_vld",  64'(grant_vld),  64'd0);
            check("idle_reg_write",  64'(reg_write),  64'd0);
            check("idle_write_reg",  64'(write_reg),  64'(last_reg));
            check("idle_write_data", 64'(write_data), 64'(last_data));
            check("idle_grant_id",   64'(grant_id),   64'(last_id));
        end
    endtask

    // Constant valid pattern for n cycles; ids holds the expected winner per cycle (3 = none).
    task automatic run_const(input logic [2:0] v, input int n, input logic [31:0] ids);
        logic [1:0] id;
        for (int k = 0; k < n; k++) begin
            id = ids[2*k +: 2];
            cycle(v, 1'b0, 1'b0, id != 2'd3, id);
            if (id != 2'd3) src_data[id] = $urandom;
        end
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) cycle(3'b111, 1'b0, 1'b1, 1'b0, 2'd0);
    endtask

    task automatic default_srcs();
        for (int i = 0; i < 3; i++) begin
            src_reg[i]  = ADDR_W'(8 + i);
            src_data[i] = $urandom;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int         i;
        logic       h;
        rst       = 1'b1;
        hold      = 1'b0;
        req_valid = 3'b000;
        last_reg  = '0;
        last_data = '0;
        last_id   = 2'd0;
        default_srcs();

        // Reset with every source requesting.
        do_reset(2);

        // Single ALU write.
        src_reg[1]  = 5'd8;
        src_data[1] = 32'hA5A5A5A5;
        cycle(3'b010, 1'b0, 1'b0, 1'b1, 2'd1);
        cycle(3'b000, 1'b0, 1'b0, 1'b0, 2'd0);

        // Full contention, then read back regs 8/9 from the image.
        do_reset(1);
        default_srcs();
        run_const(3'b111, 8, RR ? pk(0, 1, 2, 0, 1, 2, 0, 1) : pk(0, 0, 0, 0, 1, 2, 0, 0));
        cycle(3'b000, 1'b0, 1'b0, 1'b0, 2'd0);
        check("rf_reg8", 64'(rf[8]), 64'(exp_rf[8]));
        check("rf_reg9", 64'(rf[9]), 64'(exp_rf[9]));

        // Two-way contention between ALU and MUL/DIV.
        do_reset(1);
        run_const(3'b110, 6, RR ? pk(1, 2, 1, 2, 1, 2, 3, 3) : pk(1, 1, 1, 1, 2, 1, 3, 3));

        // Write to $zero is consumed but not enabled.
        src_reg[2]  = 5'd0;
        src_data[2] = 32'h5A5A5A5A;
        cycle(3'b100, 1'b0, 1'b0, 1'b1, 2'd2);
        cycle(3'b000, 1'b0, 1'b0, 1'b0, 2'd0);
        src_reg[2]  = 5'd10;

        // Hold freezes wait counters; reset dominates hold and any grant.
        do_reset(1);
        run_const(3'b011, 3, RR ? pk(0, 1, 0, 3, 3, 3, 3, 3) : pk(0, 0, 0, 3, 3, 3, 3, 3));
        for (int k = 0; k < 3; k++) cycle(3'b011, 1'b1, 1'b0, 1'b0, 2'd0);
        run_const(3'b011, 2, RR ? pk(1, 0, 3, 3, 3, 3, 3, 3) : pk(0, 1, 3, 3, 3, 3, 3, 3));
        cycle(3'b011, 1'b1, 1'b1, 1'b0, 2'd0);
        cycle(3'b011, 1'b0, 1'b0, 1'b1, 2'd0);
        cycle(3'b011, 1'b0, 1'b1, 1'b0, 2'd0);

        // Random single-source traffic, back to back, with occasional stalls.
        for (int n = 0; n < 24; n++) begin
            i           = $urandom_range(0, 2);
            src_reg[i]  = ADDR_W'($urandom_range(0, 31));
            src_data[i] = $urandom;
            h           = ($urandom_range(0, 3) == 0);
            if (h) cycle(3'b001 << i, 1'b1, 1'b0, 1'b0, 2'd0);
            cycle(3'b001 << i, 1'b0, 1'b0, 1'b1, 2'(i));
        end
        cycle(3'b000, 1'b0, 1'b0, 1'b0, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
